// File: rtl/clk_div_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_prog_pkg
// Purpose  : Shared defaults and encodings for the programmable clock divider
//            slice (ratio width, post-reset ratio, "channel off" encoding).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_prog_pkg;

    localparam int c_n_ch_default     = 4;
    localparam int c_ch_w_default     = 2;
    localparam int c_div_w_default    = 8;
    // 16.384 MHz / 10 = 1.6384 MHz after reset
    localparam int c_div_init_default = 10;
    // A ratio of zero parks the channel: outputs low, counter held
    localparam int c_div_off          = 0;

endpackage : clk_div_prog_pkg
`default_nettype wire

// File: rtl/clk_div_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_prog_if
// Purpose  : Valid/ready configuration channel of the programmable divider.
// Signals  : cfg_valid  request          (master -> slave)
//            cfg_ch     target channel   (master -> slave)
//            cfg_div    new ratio, 0=off (master -> slave)
//            cfg_ready  accept           (slave -> master)
//            cfg_err    bad-channel pulse(slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface clk_div_prog_if
    import clk_div_prog_pkg::*;
#(
    parameter int CH_W  = c_ch_w_default,
    parameter int DIV_W = c_div_w_default
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );

endinterface : clk_div_prog_if
`default_nettype wire

// File: rtl/clk_div_prog_chan.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_prog_chan
// Purpose  : One divider channel. Counts 0..D-1, emits a registered divided
//            clock (high for (D+1)>>1 cycles) and a 1-cycle ce strobe at the
//            start of each period. New ratios are staged and applied only at a
//            period boundary, immediately when parked/at D=1, or on sync.
// Ports    : clk_16_384m  system clock
//            rst_n        async active-low reset
//            load_i       stage div_i as the pending ratio
//            div_i        ratio to stage
//            sync_i       restart counter at phase 0, apply any pending ratio
//            pend_o       a staged ratio is waiting
//            active_o     current ratio is non-zero
//            clk_out_o    divided clock
//            ce_out_o     period-start strobe
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog_chan
    import clk_div_prog_pkg::*;
#(
    parameter int DIV_W    = c_div_w_default,
    parameter int DIV_INIT = c_div_init_default
)(
    input  wire logic             clk_16_384m,
    input  wire logic             rst_n,
    input  wire logic             load_i,
    input  wire logic [DIV_W-1:0] div_i,
    input  wire logic             sync_i,
    output logic                  pend_o,
    output logic                  active_o,
    output logic                  clk_out_o,
    output logic                  ce_out_o
);

    localparam logic [DIV_W-1:0] c_div_init = DIV_W'(DIV_INIT);
    localparam logic [DIV_W-1:0] c_off      = DIV_W'(c_div_off);
    localparam logic [DIV_W-1:0] c_one      = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q,      cnt_d;
    logic [DIV_W-1:0] div_cur_q,  div_cur_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q,     pend_d;
    logic             clk_q,      clk_d;
    logic             ce_q,       ce_d;

    logic [DIV_W:0]   w_hi;
    logic             w_slow;
    logic             w_wrap;
    logic             w_apply;

    // One extra bit so that D = 2^DIV_W-1 does not overflow in D+1
    assign w_hi    = ({1'b0, div_cur_q} + (DIV_W+1)'(1)) >> 1;
    // Parked (0) and D=1 have no period to finish, so a new ratio goes in now
    assign w_slow  = (div_cur_q <= c_one);
    assign w_wrap  = (cnt_q == (div_cur_q - c_one));
    assign w_apply = pend_q && (sync_i || w_slow || w_wrap);

    always_comb begin
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        clk_d      = 1'b0;
        ce_d       = 1'b0;

        // Outputs come from the pre-update count, hence one cycle behind it
        if (div_cur_q == c_off) begin
            cnt_d = '0;
        end else if (div_cur_q == c_one) begin
            clk_d = 1'b1;
            ce_d  = 1'b1;
            cnt_d = '0;
        end else begin
            ce_d  = (cnt_q == '0);
            clk_d = ({1'b0, cnt_q} < w_hi);
            cnt_d = w_wrap ? '0 : cnt_q + c_one;
        end

        if (sync_i) begin
            cnt_d = '0;
        end

        if (w_apply) begin
            div_cur_d = div_pend_q;
            cnt_d     = '0;
            pend_d    = 1'b0;
        end

        // The top only loads while no channel is pending, so load never
        // collides with an apply on this channel
        if (load_i) begin
            div_pend_d = div_i;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_16_384m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_cur_q  <= c_div_init;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            ce_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            ce_q       <= ce_d;
        end
    end

    assign pend_o    = pend_q;
    assign active_o  = (div_cur_q != c_off);
    assign clk_out_o = clk_q;
    assign ce_out_o  = ce_q;

endmodule : clk_div_prog_chan
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_prog
// Purpose  : N-channel programmable divider on clk_16_384m. Decodes the
//            config channel into per-channel load strobes, registers
//            cfg_ready/cfg_err, and fans sync out to every channel.
//            clk_out_o is for pins/observation; logic qualifies on ce_out_o.
// Ports    : clk_16_384m  system clock
//            rst_n        async active-low reset
//            cfg          config channel (slave modport)
//            sync_i       restart all channels at phase 0
//            clk_out_o    divided clock per channel
//            ce_out_o     period-start strobe per channel
//            active_o     per-channel ratio != 0
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int N_CH     = c_n_ch_default,
    parameter int CH_W     = c_ch_w_default,
    parameter int DIV_W    = c_div_w_default,
    parameter int DIV_INIT = c_div_init_default
)(
    input  wire logic            clk_16_384m,
    input  wire logic            rst_n,
    clk_div_prog_if.slave        cfg,
    input  wire logic            sync_i,
    output logic [N_CH-1:0]      clk_out_o,
    output logic [N_CH-1:0]      ce_out_o,
    output logic [N_CH-1:0]      active_o
);

    localparam logic [CH_W:0] c_n_ch = (CH_W+1)'(N_CH);

    logic            w_xfer;
    logic            w_ch_ok;
    logic [N_CH-1:0] w_load;
    logic [N_CH-1:0] w_pend;

    logic            cfg_ready_q, cfg_ready_d;
    logic            cfg_err_q,   cfg_err_d;

    assign w_xfer  = cfg.cfg_valid && cfg_ready_q;
    assign w_ch_ok = ({1'b0, cfg.cfg_ch} < c_n_ch);

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            assign w_load[i] = w_xfer && w_ch_ok && (cfg.cfg_ch == CH_W'(i));

            clk_div_prog_chan #(
                .DIV_W    (DIV_W),
                .DIV_INIT (DIV_INIT)
            ) u_chan (
                .clk_16_384m (clk_16_384m),
                .rst_n       (rst_n),
                .load_i      (w_load[i]),
                .div_i       (cfg.cfg_div),
                .sync_i      (sync_i),
                .pend_o      (w_pend[i]),
                .active_o    (active_o[i]),
                .clk_out_o   (clk_out_o[i]),
                .ce_out_o    (ce_out_o[i])
            );
        end
    endgenerate

    // Ready drops the cycle after a good transfer and stays low while any
    // channel holds a staged ratio; it returns the cycle after the apply.
    // A request to a non-existent channel is swallowed and ready stays up.
    always_comb begin
        cfg_ready_d = !(|w_pend) && !(w_xfer && w_ch_ok);
        cfg_err_d   = w_xfer && !w_ch_ok;
    end

    always_ff @(posedge clk_16_384m or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_err   = cfg_err_q;

endmodule : clk_div_prog
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_prog
// Purpose  : Self-checking bench for clk_div_prog. Per-cycle vector tables
//            (inputs + hand-computed outputs) for the 4-channel instance, and
//            hand-written sequences for the bad-channel pulse on a 3-channel
//            instance and for an asynchronous mid-period reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

    typedef struct {
        logic       v;
        logic [1:0] ch;
        logic [7:0] div;
        logic       sy;
        logic [3:0] ce;
        logic [3:0] ck;
        logic [3:0] act;
        logic       rdy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync = 1'b0;
    logic       sync3 = 1'b0;
    logic [3:0] clk_out, ce_out, active;
    logic [2:0] clk_out3, ce_out3, active3;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    clk_div_prog_if #(.CH_W(2), .DIV_W(8)) cfg_if ();
    clk_div_prog_if #(.CH_W(2), .DIV_W(8)) cfg_if3 ();

    clk_div_prog #(.N_CH(4), .CH_W(2), .DIV_W(8), .DIV_INIT(10)) dut (
        .clk_16_384m (clk),
        .rst_n       (rst_n),
        .cfg         (cfg_if),
        .sync_i      (sync),
        .clk_out_o   (clk_out),
        .ce_out_o    (ce_out),
        .active_o    (active)
    );

    clk_div_prog #(.N_CH(3), .CH_W(2), .DIV_W(8), .DIV_INIT(10)) dut3 (
        .clk_16_384m (clk),
        .rst_n       (rst_n),
        .cfg         (cfg_if3),
        .sync_i      (sync3),
        .clk_out_o   (clk_out3),
        .ce_out_o    (ce_out3),
        .active_o    (active3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic v, input logic [1:0] ch, input logic [7:0] d, input logic sy,
                       input logic [3:0] ce, input logic [3:0] ck, input logic [3:0] act,
                       input logic rdy);
        vec_t r;
        r.v = v; r.ch = ch; r.div = d; r.sy = sy;
        r.ce = ce; r.ck = ck; r.act = act; r.rdy = rdy;
        vecs.push_back(r);
    endtask

    task automatic add_idle(input int n, input logic [3:0] ce, input logic [3:0] ck,
                            input logic [3:0] act, input logic rdy);
        for (int j = 0; j < n; j++) add(1'b0, 2'd0, 8'd0, 1'b0, ce, ck, act, rdy);
    endtask

    // Row k is driven before edge k after reset release and checked after it.
    // Packed compare order: {ce, clk_out, active, cfg_ready, cfg_err}
    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            cfg_if.cfg_valid = vecs[i].v;
            cfg_if.cfg_ch    = vecs[i].ch;
            cfg_if.cfg_div   = vecs[i].div;
            sync             = vecs[i].sy;
            tick();
            chk($sformatf("%s k=%0d ce/clk/act/rdy/err", tag, i + 1),
                {18'd0, ce_out, clk_out, active, cfg_if.cfg_ready, cfg_if.cfg_err},
                {18'd0, vecs[i].ce, vecs[i].ck, vecs[i].act, vecs[i].rdy, 1'b0});
        end
        vecs.delete();
        cfg_if.cfg_valid = 1'b0;
        sync             = 1'b0;
    endtask

    // Leaves time at 1 ns after an edge with reset just released
    task automatic do_reset(input string tag);
        tick();
        rst_n = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if3.cfg_valid = 1'b0;
        sync  = 1'b0;
        sync3 = 1'b0;
        tick();
        chk({tag, " reset state"},
            {14'd0, ce_out, clk_out, active, cfg_if.cfg_ready, cfg_if.cfg_err},
            {14'd0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0});
        tick();
        rst_n = 1'b1;
    endtask

    task automatic add_default_period();
        add_idle(1, 4'hF, 4'hF, 4'hF, 1'b1);
        add_idle(4, 4'h0, 4'hF, 4'hF, 1'b1);
        add_idle(5, 4'h0, 4'h0, 4'hF, 1'b1);
        add_idle(1, 4'hF, 4'hF, 4'hF, 1'b1);
    endtask

    initial begin
        cfg_if.cfg_valid  = 1'b0; cfg_if.cfg_ch  = 2'd0; cfg_if.cfg_div  = 8'd0;
        cfg_if3.cfg_valid = 1'b0; cfg_if3.cfg_ch = 2'd0; cfg_if3.cfg_div = 8'd0;

        // Defaults, then ch1 -> 5 after the running 10-cycle period
        do_reset("A");
        add(1'b1, 2'd1, 8'd5, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0);
        add_idle(4, 4'h0, 4'hF, 4'hF, 1'b0);
        add_idle(5, 4'h0, 4'h0, 4'hF, 1'b0);
        add_idle(1, 4'hF, 4'hF, 4'hF, 1'b1);
        add_idle(2, 4'h0, 4'hF, 4'hF, 1'b1);
        add_idle(2, 4'h0, 4'hD, 4'hF, 1'b1);
        add_idle(1, 4'h2, 4'h2, 4'hF, 1'b1);
        add_idle(2, 4'h0, 4'h2, 4'hF, 1'b1);
        add_idle(2, 4'h0, 4'h0, 4'hF, 1'b1);
        add_idle(1, 4'hF, 4'hF, 4'hF, 1'b1);
        run_table("A");

        // ch0 -> 4 written at cnt=3; a second request is held off by ready=0
        do_reset("B");
        add_idle(1, 4'hF, 4'hF, 4'hF, 1'b1);
        add_idle(2, 4'h0, 4'hF, 4'hF, 1'b1);
        add(1'b1, 2'd0, 8'd4, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0);
        add(1'b1, 2'd2, 8'd7, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0);
        for (int j = 0; j < 3; j++) add(1'b1, 2'd2, 8'd7, 1'b0, 4'h0, 4'h0, 4'hF, 1'b0);
        add_idle(2, 4'h0, 4'h0, 4'hF, 1'b0);
        add_idle(1, 4'hF, 4'hF, 4'hF, 1'b1);
        add_idle(1, 4'h0, 4'hF, 4'hF, 1'b1);
        add_idle(2, 4'h0, 4'hE, 4'hF, 1'b1);
        add_idle(1, 4'h1, 4'hF, 4'hF, 1'b1);
        add_idle(1, 4'h0, 4'h1, 4'hF, 1'b1);
        add_idle(2, 4'h0, 4'h0, 4'hF, 1'b1);
        add_idle(1, 4'h1, 4'h1, 4'hF, 1'b1);
        add_idle(1, 4'h0, 4'h1, 4'hF, 1'b1);
        add_idle(1, 4'hE, 4'hE, 4'hF, 1'b1);
        run_table("B");

        // ch2: off, then 3 (immediate), then 1 (at wrap), then 2 (immediate)
        do_reset("C");
        add(1'b1, 2'd2, 8'd0, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0);
        add_idle(4, 4'h0, 4'hF, 4'hF, 1'b0);
        add_idle(4, 4'h0, 4'h0, 4'hF, 1'b0);
        add_idle(1, 4'h0, 4'h0, 4'hB, 1'b0);
        add_idle(1, 4'hB, 4'hB, 4'hB, 1'b1);
        add(1'b1, 2'd2, 8'd3, 1'b0, 4'h0, 4'hB, 4'hB, 1'b0);
        add_idle(1, 4'h0, 4'hB, 4'hF, 1'b0);
        add_idle(1, 4'h4, 4'hF, 4'hF, 1'b1);
        add(1'b1, 2'd2, 8'd1, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0);
        add_idle(1, 4'h0, 4'h0, 4'hF, 1'b0);
        add_idle(1, 4'h4, 4'h4, 4'hF, 1'b1);
        add(1'b1, 2'd2, 8'd2, 1'b0, 4'h4, 4'h4, 4'hF, 1'b0);
        add_idle(1, 4'h4, 4'h4, 4'hF, 1'b0);
        add_idle(1, 4'h4, 4'h4, 4'hF, 1'b1);
        add_idle(1, 4'hB, 4'hB, 4'hF, 1'b1);
        add_idle(1, 4'h4, 4'hF, 4'hF, 1'b1);
        add_idle(1, 4'h0, 4'hB, 4'hF, 1'b1);
        run_table("C");

        // sync applies ch3's pending 6; a transfer alongside sync waits for wrap
        do_reset("D");
        add(1'b1, 2'd3, 8'd6, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0);
        add_idle(2, 4'h0, 4'hF, 4'hF, 1'b0);
        add(1'b0, 2'd0, 8'd0, 1'b1, 4'h0, 4'hF, 4'hF, 1'b0);
        add_idle(1, 4'hF, 4'hF, 4'hF, 1'b1);
        add(1'b1, 2'd1, 8'd4, 1'b1, 4'h0, 4'hF, 4'hF, 1'b0);
        add_idle(1, 4'hF, 4'hF, 4'hF, 1'b0);
        add_idle(2, 4'h0, 4'hF, 4'hF, 1'b0);
        add_idle(2, 4'h0, 4'h7, 4'hF, 1'b0);
        add_idle(1, 4'h0, 4'h0, 4'hF, 1'b0);
        add_idle(1, 4'h8, 4'h8, 4'hF, 1'b0);
        add_idle(2, 4'h0, 4'h8, 4'hF, 1'b0);
        add_idle(1, 4'h0, 4'h0, 4'hF, 1'b0);
        add_idle(1, 4'h7, 4'h7, 4'hF, 1'b1);
        add_idle(1, 4'h0, 4'h7, 4'hF, 1'b1);
        run_table("D");

        // 3-channel instance: cfg_ch=3 is accepted, flagged and dropped
        do_reset("E");
        cfg_if3.cfg_valid = 1'b1;
        cfg_if3.cfg_ch    = 2'd3;
        cfg_if3.cfg_div   = 8'd5;
        tick();
        cfg_if3.cfg_valid = 1'b0;
        chk("E err pulse ce/clk/act/rdy/err",
            {ce_out3, clk_out3, active3, cfg_if3.cfg_ready, cfg_if3.cfg_err},
            {3'h7, 3'h7, 3'h7, 1'b1, 1'b1});
        tick();
        chk("E err cleared ce/clk/act/rdy/err",
            {ce_out3, clk_out3, active3, cfg_if3.cfg_ready, cfg_if3.cfg_err},
            {3'h0, 3'h7, 3'h7, 1'b1, 1'b0});
        repeat (3) tick();
        chk("E k5 ce/clk", {ce_out3, clk_out3}, {3'h0, 3'h7});
        repeat (6) tick();
        chk("E k11 ce/clk", {ce_out3, clk_out3}, {3'h7, 3'h7});

        // Async reset mid-period after ch0 moved to 4; ratios return to 10
        do_reset("F");
        add(1'b1, 2'd0, 8'd4, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0);
        add_idle(4, 4'h0, 4'hF, 4'hF, 1'b0);
        add_idle(5, 4'h0, 4'h0, 4'hF, 1'b0);
        add_idle(1, 4'hF, 4'hF, 4'hF, 1'b1);
        add_idle(1, 4'h0, 4'hF, 4'hF, 1'b1);
        run_table("F");
        #3;
        rst_n = 1'b0;
        #1;
        chk("F async reset ce/clk/act/rdy/err",
            {ce_out, clk_out, active, cfg_if.cfg_ready, cfg_if.cfg_err},
            {4'h0, 4'h0, 4'hF, 1'b1, 1'b0});
        tick();
        tick();
        rst_n = 1'b1;
        add_default_period();
        run_table("F post-reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_clk_div_prog
`default_nettype wire
